mips32_reg_dump: RTL and testbench

Post-halt register-file readout engine for the pipelined MIPS32 core. It drives the register-file read port itself, walks registers R0 upward, and streams each value out over a valid/ready interface. Regression benches and the debug link therefore read architectural state through hardware instead of hierarchical peeks. It is armed when the core raises HALTED and sits beside the core, on the core's register-file read port.

---
 rtl/mips32_pkg.sv | 18 +
 rtl/mips32_edge_det.sv | 35 +++
 rtl/mips32_reg_dump.sv | 179 +++++++++++++++++
 tb/tb_mips32_reg_dump.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 register-dump engine.
// Optional checksum beat: define MIPS32_DUMP_CKSUM_EN to add the CKSUM state.
package mips32_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SEND  = 3'd3
`ifdef MIPS32_DUMP_CKSUM_EN
    , ST_CKSUM = 3'd4
`endif
  } dump_state_e;

endpackage

// File: rtl/mips32_edge_det.sv
// Rising-edge detector for the core HALTED flag.
// The first clock after reset only loads the history flop, so a level that
// is already high when reset releases is not seen as an edge.
module mips32_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed_q;
  logic d_d;
  logic armed_d;

  // Next history value and arming flag
  always_comb begin
    d_d     = d;
    armed_d = 1'b1;
  end

  // History and arming registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      armed_q <= armed_d;
    end
  end

  assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file readout engine: walks R0..R(NUM_REGS-1) through the
// register-file read port and streams each value over valid/ready.
// Optional checksum beat: define MIPS32_DUMP_CKSUM_EN.
module mips32_reg_dump
  import mips32_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              start,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_cksum,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
`ifdef MIPS32_DUMP_CKSUM_EN
  logic              out_cksum_q, out_cksum_d;
  logic [DATA_W-1:0] xor_q, xor_d;
`endif

  logic halted_rise;
  logic trig;
  logic is_last;

  mips32_edge_det u_edge (
    .clk  (clk1),
    .rst  (rst),
    .d    (halted),
    .rise (halted_rise)
  );

  assign trig    = halted_rise | start;
  assign is_last = (idx_q == IDX_W'(NUM_REGS - 1));

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef MIPS32_DUMP_CKSUM_EN
    out_cksum_d = out_cksum_q;
    xor_d       = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          idx_d   = '0;
          state_d = ST_READ;
`ifdef MIPS32_DUMP_CKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_READ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        out_data_d  = rf_data;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef MIPS32_DUMP_CKSUM_EN
        out_last_d  = 1'b0;
        xor_d       = xor_q ^ rf_data;
`else
        out_last_d  = is_last;
`endif
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef MIPS32_DUMP_CKSUM_EN
          // The checksum beat reuses SEND; out_cksum_q tells it apart from
          // the last register beat.
          out_cksum_d = 1'b0;
          if (out_cksum_q) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else if (is_last) begin
            state_d = ST_CKSUM;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
          end
`else
          if (is_last) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
          end
`endif
        end
      end
`ifdef MIPS32_DUMP_CKSUM_EN
      ST_CKSUM: begin
        out_data_d  = xor_q;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_cksum_d = 1'b1;
        state_d     = ST_SEND;
      end
`endif
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef MIPS32_DUMP_CKSUM_EN
      out_cksum_q <= 1'b0;
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef MIPS32_DUMP_CKSUM_EN
      out_cksum_q <= out_cksum_d;
      xor_q       <= xor_d;
`endif
    end
  end

  // idx_q is cleared on every return to IDLE, so the read port idles at R0.
  assign rf_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
`ifdef MIPS32_DUMP_CKSUM_EN
  assign out_cksum = out_cksum_q;
`else
  assign out_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Self-checking bench for mips32_reg_dump (32-register and 1-register builds).
module tb_mips32_reg_dump;

`ifdef MIPS32_DUMP_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst, halted, start, out_ready;
  logic [4:0]  rf_addr, out_idx;
  logic [31:0] rf_data, out_data;
  logic        out_valid, out_last, out_cksum, busy, done;

  logic        start1, halted1, out_ready1;
  logic [4:0]  rf_addr1, out_idx1;
  logic [31:0] rf_data1, out_data1;
  logic        out_valid1, out_last1, out_cksum1, busy1, done1;

  mips32_reg_dump #(.NUM_REGS(32)) dut (
    .clk1(clk1), .rst(rst), .halted(halted), .start(start),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_cksum(out_cksum),
    .busy(busy), .done(done)
  );

  mips32_reg_dump #(.NUM_REGS(1)) dut1 (
    .clk1(clk1), .rst(rst), .halted(halted1), .start(start1),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1), .out_cksum(out_cksum1),
    .busy(busy1), .done(done1)
  );

  // Register file: synchronous read, data for last cycle's address
  logic [31:0] regs [32];
  always @(posedge clk1) rf_data  <= regs[rf_addr];
  always @(posedge clk1) rf_data1 <= regs[rf_addr1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequence of beats a dump of the current file must produce
  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        ck;
  } beat_t;
  beat_t exp_q[$];

  function automatic logic [31:0] xor_regs();
    logic [31:0] acc = '0;
    for (int k = 0; k < 32; k++) acc ^= regs[k];
    return acc;
  endfunction

  function automatic void push_dump();
    beat_t b;
    for (int k = 0; k < 32; k++) begin
      b.data = regs[k];
      b.idx  = k[4:0];
      b.last = (k == 31) && !CK;
      b.ck   = 1'b0;
      exp_q.push_back(b);
    end
    if (CK) begin
      b.data = xor_regs();
      b.idx  = 5'd31;
      b.last = 1'b1;
      b.ck   = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: handshakes against the model, stall stability, done timing
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_idx = '0;
  logic        done_exp = 1'b0;
  time         t_done = 0;

  always @(negedge clk1) begin
    logic  done_next;
    beat_t e;
    if (rst) begin
      prev_valid = 1'b0;
      done_exp   = 1'b0;
    end else begin
      chk("done_pulse", done, done_exp);
      if (done) t_done = $time;
      if (out_valid) chk("busy_with_valid", busy, 1);
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_idx", out_idx, prev_idx);
        chk("stall_last", out_last, prev_last);
      end
      done_next = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_last", out_last, e.last);
          chk("beat_cksum", out_cksum, e.ck);
          done_next = e.last;
        end
      end
      done_exp   = done_next;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  // Sink ready driver: 0 = always ready, 1 = random, 2 = stall beat 4
  int rmode = 0;
  int stall_left = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk1);
      #2;
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && out_idx == 5'd4 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk1);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) break;
      cyc(1);
    end
    if (i == budget) chk(name, busy, 0);
  endtask

  time t_trig;

  initial begin
    rst = 1'b1; halted = 1'b0; start = 1'b0;
    start1 = 1'b0; halted1 = 1'b0; out_ready1 = 1'b1;
    for (int k = 0; k < 32; k++) regs[k] = k;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_cksum", out_cksum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_addr", rf_addr, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Directed dump triggered by the halted edge, sink always ready
    regs[1] = 10; regs[2] = 20; regs[3] = 25; regs[4] = 30; regs[5] = 55;
    push_dump();
    chk("model_r5", exp_q[5].data, 55);
    chk("model_idx31", exp_q[31].idx, 31);
    chk("model_xor", xor_regs(), 32'h2F);
    t_done = 0;
    halted = 1'b1;
    @(posedge clk1);
    t_trig = $time;
    #2;
    wait_idle(300, "timeout_directed");
    cyc(2);
`ifndef MIPS32_DUMP_CKSUM_EN
    chk("done_latency", 32'((t_done - t_trig) / 10), 96);
`endif
    chk("rf_addr_idle", rf_addr, 0);
    halted = 1'b0;
    cyc(2);

    // Sink stalls for 10 cycles on beat 4
    push_dump();
    rmode = 2; stall_left = 10;
    start = 1'b1; cyc(1); start = 1'b0;
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk1);
        if (out_valid && out_idx == 5'd4) break;
      end
      if (i == 100) chk("timeout_beat4", out_valid, 1);
      for (int j = 0; j < 10; j++) begin
        chk("stall4_data", out_data, 30);
        chk("stall4_idx", out_idx, 4);
        @(negedge clk1);
      end
    end
    cyc(1);
    wait_idle(300, "timeout_stall");
    rmode = 0;
    cyc(2);

    // Simultaneous halted edge and start, then a start while busy
    push_dump();
    halted = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_after_trig", busy, 1);
    cyc(20);
    start = 1'b1; cyc(1); start = 1'b0;
    wait_idle(300, "timeout_simul");
    cyc(10);
    chk("no_second_dump_busy", busy, 0);
    chk("no_second_dump_valid", out_valid, 0);

    // Reset at beat 7 with halted held high across release
    halted = 1'b0;
    cyc(3);
    push_dump();
    halted = 1'b1;
    cyc(1);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        if (out_valid && out_idx == 5'd7) break;
        cyc(1);
      end
      if (i == 100) chk("timeout_beat7", out_valid, 1);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rf_addr", rf_addr, 0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    chk("no_retrigger_busy", busy, 0);
    chk("no_retrigger_valid", out_valid, 0);

    // Random register contents and random sink back-pressure
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      rmode = 1;
      push_dump();
      if (it % 2 == 1) begin
        start = 1'b1; cyc(1); start = 1'b0;
      end else begin
        halted = 1'b0; cyc(2);
        halted = 1'b1; cyc(1);
      end
      cyc(30);
      halted = 1'b0;
      wait_idle(2000, "timeout_random");
      rmode = 0;
      cyc(3);
    end

    // Single-register build
    regs[0] = 32'h0;
    start1 = 1'b1; cyc(1); start1 = 1'b0;
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(negedge clk1);
        if (out_valid1) break;
      end
      if (i == 50) chk("timeout_n1", out_valid1, 1);
      chk("n1_data", out_data1, 0);
      chk("n1_idx", out_idx1, 0);
      chk("n1_cksum_first", out_cksum1, 0);
`ifdef MIPS32_DUMP_CKSUM_EN
      chk("n1_last_reg", out_last1, 0);
      for (i = 0; i < 50; i++) begin
        @(negedge clk1);
        if (out_valid1) break;
      end
      if (i == 50) chk("timeout_n1_ck", out_valid1, 1);
      chk("n1_ck_data", out_data1, 0);
      chk("n1_ck_flag", out_cksum1, 1);
      chk("n1_ck_last", out_last1, 1);
`else
      chk("n1_last", out_last1, 1);
`endif
      @(negedge clk1);
      chk("n1_done", done1, 1);
      chk("n1_busy", busy1, 0);
    end
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
